// File: rtl/axi_pkg.sv
// AXI response encodings and index-width helper shared by the B and R channel muxes.
package axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from rr_ptr, wrapping at N.
// Latency: combinational grant; pointer moves to winner+1 on the clock after en && |req.
// Backpressure: en low forces gnt to zero and freezes the pointer.
module rr_arbiter
    import axi_pkg::*;
#(
    parameter  int N     = 4,
    localparam int SEL_W = sel_w(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] gnt_idx
);

    localparam logic [SEL_W:0]   N_L  = (SEL_W+1)'(N);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W:0]   w_sum;
    logic [SEL_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_sum   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + (SEL_W+1)'(k);
            if (w_sum >= N_L) begin
                w_sum = w_sum - N_L;
            end
            if (!w_found && req[w_sum[SEL_W-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_sum[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = en && w_found && (w_idx == SEL_W'(i));
        end
    end

    assign gnt_idx = w_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (en && w_found) begin
            r_ptr <= (w_idx == LAST) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/axi_wr_rsp_mux.sv
// Merges N_SLV AXI B channels into one, BID widened with source index; optional AXI_WR_RSP_ERR_CNT_EN error counter.
// Latency: 1 cycle from downstream handshake to m_bvalid; 1 response/cycle sustained.
// Backpressure: grants stop when the output FIFO is full unless it is popped in the same cycle.
module axi_wr_rsp_mux
    import axi_pkg::*;
#(
    parameter  int N_SLV     = 4,
    parameter  int ID_WIDTH  = 4,
    parameter  int OUT_DEPTH = 2,
    localparam int SEL_W     = sel_w(N_SLV)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_SLV-1:0]          s_bvalid,
    output logic [N_SLV-1:0]          s_bready,
    input  logic [N_SLV*ID_WIDTH-1:0] s_bid,
    input  logic [N_SLV*2-1:0]        s_bresp,
    input  logic [N_SLV-1:0]          s_buser,
    output logic                      m_bvalid,
    input  logic                      m_bready,
    output logic [SEL_W+ID_WIDTH-1:0] m_bid,
    output logic [1:0]                m_bresp,
    output logic                      m_buser
`ifdef AXI_WR_RSP_ERR_CNT_EN
    ,
    output logic [15:0]               err_cnt
`endif
);

    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(OUT_DEPTH);

    typedef struct packed {
        logic [SEL_W+ID_WIDTH-1:0] id;
        logic [1:0]                resp;
        logic                      user;
    } b_beat_t;

    b_beat_t          r_mem [OUT_DEPTH];
    b_beat_t          r_out;
    b_beat_t          w_push_dat;
    b_beat_t          w_nxt_out;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_pop;
    logic             w_push;
    logic             w_en;
    logic [N_SLV-1:0] w_gnt;
    logic [SEL_W-1:0] w_gnt_idx;

    logic [ID_WIDTH-1:0] w_bid   [N_SLV];
    logic [1:0]          w_bresp [N_SLV];

    for (genvar g = 0; g < N_SLV; g++) begin : g_unpack
        assign w_bid[g]   = s_bid[g*ID_WIDTH +: ID_WIDTH];
        assign w_bresp[g] = s_bresp[g*2 +: 2];
    end

    assign m_bvalid = (r_cnt != '0);
    assign w_pop    = m_bvalid && m_bready;
    // A full FIFO may still accept when the head leaves this same cycle.
    assign w_en     = rst_n && ((r_cnt < DEPTH_L) || w_pop);

    rr_arbiter #(.N(N_SLV)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (s_bvalid),
        .en      (w_en),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign s_bready = w_gnt;
    assign w_push   = |w_gnt;

    always_comb begin
        w_push_dat      = '0;
        w_push_dat.id   = {w_gnt_idx, w_bid[w_gnt_idx]};
        w_push_dat.resp = w_bresp[w_gnt_idx];
        w_push_dat.user = s_buser[w_gnt_idx];
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + 1'b1;
            2'b01:   w_cnt_nxt = r_cnt - 1'b1;
            default: w_cnt_nxt = r_cnt;
        endcase
        w_rd_ptr_nxt = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
    end

    // Head register: bypass the incoming beat when it becomes the only entry; hold when empty.
    always_comb begin
        w_nxt_out = r_out;
        if (w_cnt_nxt != '0) begin
            if ((r_cnt == '0) || ((r_cnt == CNT_W'(1)) && w_pop)) begin
                w_nxt_out = w_push_dat;
            end else begin
                w_nxt_out = r_mem[w_rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_out    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_out    <= w_nxt_out;
        end
    end

    assign m_bid   = r_out.id;
    assign m_bresp = r_out.resp;
    assign m_buser = r_out.user;

`ifdef AXI_WR_RSP_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_pop && m_bresp[1] && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule
